sram_column_seq: RTL and testbench

SRAM_COLUMN_SEQ -- requirements
Module: sram_column_seq

---
 rtl/sram_column_seq.sv | 141 ++++++++++++++
 tb/tb_sram_column_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_column_seq.sv
// SRAM compute-column sequencer.
// Accepts one request (packed twiddle bit-planes plus four positive and four
// negative 6-bit row operands). It then drives the column one twiddle plane
// per cycle, MSB plane first, and accumulates the column's (pos - neg) sum
// with binary plane weighting. The signed result is held on a valid/ready
// output until the consumer takes it. Supported N_PLANES range: 2..4.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// RUN   | one plane per cycle on col_twiddle, accumulating column sums
// DONE  | result presented with out_valid until out_ready
module sram_column_seq #(
    parameter int N_PLANES = 4,
    parameter int RESULT_W = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*N_PLANES-1:0]      twiddle_word,
    input  logic [23:0]                data_pos,
    input  logic [23:0]                data_neg,
    output logic [3:0]                 col_twiddle,
    output logic [23:0]                col_data_pos,
    output logic [23:0]                col_data_neg,
    input  logic [12:0]                col_pos_sum,
    input  logic [12:0]                col_neg_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [RESULT_W-1:0] result
);

    localparam int K_W = (N_PLANES > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        run_en;
    logic                        accept;
    logic                        last_plane;
    logic [K_W-1:0]              k_q;
    logic [4*N_PLANES-1:0]       tw_q;
    logic [23:0]                 pos_q;
    logic [23:0]                 neg_q;
    logic signed [RESULT_W-1:0]  acc_q;
    logic signed [RESULT_W-1:0]  result_q;
    logic signed [RESULT_W-1:0]  pos_ext;
    logic signed [RESULT_W-1:0]  neg_ext;
    logic signed [RESULT_W-1:0]  acc_step;

    assign accept     = in_ready && in_valid;
    assign last_plane = (k_q == '0);

    // Column sums are unsigned magnitudes; widen before the signed subtract.
    assign pos_ext  = RESULT_W'(col_pos_sum);
    assign neg_ext  = RESULT_W'(col_neg_sum);
    assign acc_step = (acc_q <<< 1) + pos_ext - neg_ext;

    assign col_data_pos = pos_q;
    assign col_data_neg = neg_q;
    assign result       = result_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; reset forces the idle-looking outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        run_en    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                run_en = 1'b1;
                if (last_plane) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d   = IDLE;
            in_ready  = 1'b1;
            out_valid = 1'b0;
            run_en    = 1'b0;
        end
    end

    // Select the current plane from the latched word while running.
    always_comb begin
        col_twiddle = 4'b0000;
        if (run_en) begin
            for (int i = 0; i < N_PLANES; i++) begin
                if (int'(k_q) == i) col_twiddle = tw_q[4*i +: 4];
            end
        end
    end

    // Operand latch, plane counter and accumulator; result captured on the last plane.
    always_ff @(posedge clk) begin
        if (rst) begin
            tw_q     <= '0;
            pos_q    <= '0;
            neg_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            tw_q  <= twiddle_word;
            pos_q <= data_pos;
            neg_q <= data_neg;
            k_q   <= K_W'(N_PLANES - 1);
            acc_q <= '0;
        end else if (run_en) begin
            acc_q <= acc_step;
            if (last_plane) begin
                result_q <= acc_step;
            end else begin
                k_q <= k_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_column_seq.sv
// Bench for sram_column_seq with a behavioural column (beta=2, n=4: each
// column sum is 16x the sum of twiddle-gated row operands).
module tb_sram_column_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        twiddle_word;
    logic [23:0]        data_pos;
    logic [23:0]        data_neg;
    logic [3:0]         col_twiddle;
    logic [23:0]        col_data_pos;
    logic [23:0]        col_data_neg;
    logic [12:0]        col_pos_sum;
    logic [12:0]        col_neg_sum;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] result;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    sram_column_seq #(.N_PLANES(4), .RESULT_W(18)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .twiddle_word (twiddle_word),
        .data_pos     (data_pos),
        .data_neg     (data_neg),
        .col_twiddle  (col_twiddle),
        .col_data_pos (col_data_pos),
        .col_data_neg (col_data_neg),
        .col_pos_sum  (col_pos_sum),
        .col_neg_sum  (col_neg_sum),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Column model: col_twiddle bit 3 gates row 0, bit 0 gates row 3.
    always_comb begin
        logic [12:0] ps;
        logic [12:0] ns;
        ps = '0;
        ns = '0;
        for (int r = 0; r < 4; r++) begin
            if (col_twiddle[3-r]) begin
                ps = ps + {7'b0, col_data_pos[6*r +: 6]};
                ns = ns + {7'b0, col_data_neg[6*r +: 6]};
            end
        end
        col_pos_sum = {ps[8:0], 4'b0000};
        col_neg_sum = {ns[8:0], 4'b0000};
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [15:0] tw, input logic [23:0] p, input logic [23:0] n);
        int acc = 0;
        for (int k = 3; k >= 0; k--) begin
            int s = 0;
            for (int r = 0; r < 4; r++) begin
                if (tw[4*k + 3 - r]) s += 16 * (int'(p[6*r +: 6]) - int'(n[6*r +: 6]));
            end
            acc = acc * 2 + s;
        end
        return acc;
    endfunction

    // Entered just after a negedge with the DUT idle; leaves just after the
    // negedge following the output handshake.
    task automatic run_op(input logic [15:0] tw, input logic [23:0] p, input logic [23:0] n,
                          input int exp, input int stall, input bit hold_valid);
        int got;
        chk("in_ready_idle", int'(in_ready), 1);
        in_valid     = 1'b1;
        twiddle_word = tw;
        data_pos     = p;
        data_neg     = n;
        exp_q.push_back(exp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (hold_valid) begin
                data_pos = ~p;
                data_neg = ~n;
                twiddle_word = ~tw;
            end else begin
                in_valid = 1'b0;
            end
            chk("run_out_valid", int'(out_valid), 0);
            chk("run_in_ready", int'(in_ready), 0);
            chk("col_twiddle", int'(col_twiddle), int'(tw[4*(3-i) +: 4]));
            chk("col_data_pos", int'(col_data_pos), int'(p));
            chk("col_data_neg", int'(col_data_neg), int'(n));
        end
        @(negedge clk);
        chk("latency_out_valid", int'(out_valid), 1);
        chk("done_in_ready", int'(in_ready), 0);
        out_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_result", int'(result), exp);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_col_data_pos", int'(col_data_pos), int'(p));
        end
        out_ready = 1'b1;
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("result_sb", int'(result), got);
        end else begin
            chk("sb_underflow", 0, 1);
        end
        @(negedge clk);
        chk("one_cycle_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
        chk("result_hold", int'(result), exp);
        if (!hold_valid) in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] tw;
        logic [23:0] p;
        logic [23:0] n;

        rst          = 1'b1;
        in_valid     = 1'b0;
        twiddle_word = '0;
        data_pos     = '0;
        data_neg     = '0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_col_twiddle", int'(col_twiddle), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_col_data_pos", int'(col_data_pos), 0);
        chk("rst_col_data_neg", int'(col_data_neg), 0);

        // All rows +1, all planes fully on.
        run_op(16'hFFFF, {4{6'd1}}, 24'd0, 960, 0, 1'b0);
        // Only MSB plane, row 0 = 63.
        run_op(16'h8000, 24'd63, 24'd0, 8064, 0, 1'b0);
        // Negative extreme on row 0.
        run_op(16'hFFFF, 24'd0, 24'd63, -15120, 0, 1'b0);
        // Positive maximum.
        run_op(16'hFFFF, {4{6'd63}}, 24'd0, 60480, 0, 1'b0);
        // Stall in DONE with in_valid held; next op accepted right after the handshake.
        run_op(16'hA5C3, 24'h3F_0A_11, 24'h05_20_3F, model(16'hA5C3, 24'h3F_0A_11, 24'h05_20_3F), 3, 1'b1);
        run_op(16'h1234, 24'h12_34_56, 24'h65_43_21, model(16'h1234, 24'h12_34_56, 24'h65_43_21), 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            tw = 16'($urandom_range(0, 65535));
            p  = 24'($urandom);
            n  = 24'($urandom);
            run_op(tw, p, n, model(tw, p, n), t % 3, 1'b0);
        end

        // Reset during the second RUN cycle.
        in_valid     = 1'b1;
        twiddle_word = 16'hFFFF;
        data_pos     = {4{6'd9}};
        data_neg     = 24'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_col_twiddle", int'(col_twiddle), 15);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_col_twiddle", int'(col_twiddle), 0);
        chk("midrst_col_data_pos", int'(col_data_pos), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_pulse", int'(out_valid), 0);
        end

        // Normal operation after the interrupted one.
        run_op(16'h0F0F, {4{6'd5}}, {4{6'd2}}, model(16'h0F0F, {4{6'd5}}, {4{6'd2}}), 1, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
